hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding for E, load-use interlock,
// branch/jump flushes, and a memory-wait FSM that freezes the pipeline while a
// data access in M is outstanding and latches a bus error on timeout.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no access outstanding; a same-cycle ack is a zero-wait access
//   S_WAIT | access in M not yet acknowledged; timer counts waited cycles
//   S_ERR  | access timed out; pipeline frozen and BusErr held until reset
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemAckM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        BusErr,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ERR  = 2'b10
    } mem_state_t;

    mem_state_t  state;
    logic [3:0]  timer;
    logic        bus_err_q;
    logic [15:0] stall_count_q;
    logic        lw_stall;
    logic        mem_stall;

    // Forwarding select: the younger producer in M wins over the one in W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Combinational so the freeze already applies in the request cycle.
    assign mem_stall = ((state == S_IDLE) && MemReqM && !MemAckM) ||
                       ((state == S_WAIT) && !MemAckM) ||
                       (state == S_ERR);

    // Stall/flush resolution: memory freeze beats branch flush beats load-use.
    // During a freeze the redirect is held off; E keeps PCSrcE so it re-applies
    // once the access completes.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // Memory wait FSM with a 4-bit wait timer; ERR is left only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= 4'd0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemReqM && !MemAckM) begin
                        state <= S_WAIT;
                        timer <= 4'd1;
                    end
                end
                S_WAIT: begin
                    if (MemAckM) begin
                        state <= S_IDLE;
                        timer <= 4'd0;
                    end else if (timer == 4'd15) begin
                        state     <= S_ERR;
                        bus_err_q <= 1'b1;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                S_ERR: begin
                    bus_err_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    timer <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the fetch stage is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count_q <= 16'd0;
        else if (StallF && (stall_count_q != 16'hFFFF))
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign BusErr     = bus_err_q;
    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, all
// compared against a behavioural model that tracks how many consecutive
// cycles the memory access has been stalling.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemAckM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        BusErr;
    logic [15:0] StallCount;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .BusErr(BusErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: consecutive memory-stall cycles, sticky error, stall count.
    int m_age;
    bit m_err;
    int m_cnt;
    bit e_ms, e_sf;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic zero_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; MemReqM = 0; MemAckM = 0;
    endtask

    // Evaluate expectations at the falling edge and optionally compare.
    task automatic eval_cycle(input bit do_check);
        bit lw;
        @(negedge clk);
        lw   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        e_ms = m_err || (!MemAckM && (m_age > 0 || MemReqM));
        e_sf = e_ms || lw;
        if (do_check) begin
            check_val("ForwardAE", ForwardAE, fwd_sel(Rs1E));
            check_val("ForwardBE", ForwardBE, fwd_sel(Rs2E));
            check_val("StallF", StallF, e_sf);
            check_val("StallD", StallD, e_sf);
            check_val("StallE", StallE, e_ms);
            check_val("StallM", StallM, e_ms);
            check_val("FlushD", FlushD, !e_ms && PCSrcE);
            check_val("FlushE", FlushE, !e_ms && (PCSrcE || lw));
            check_val("FlushW", FlushW, e_ms);
            check_val("BusErr", BusErr, m_err);
            check_val("StallCount", StallCount, m_cnt[15:0]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!m_err) begin
            if (e_ms) begin
                m_age++;
                if (m_age >= 16) m_err = 1;
            end else begin
                m_age = 0;
            end
        end
        if (e_sf && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic cyc(input bit do_check);
        eval_cycle(do_check);
        advance();
    endtask

    // Asynchronous reset applied between clock edges; checked before any edge.
    task automatic do_reset();
        zero_inputs();
        #2 rst_n = 0;
        #1;
        m_age = 0; m_err = 0; m_cnt = 0;
        check_val("rst_BusErr", BusErr, 16'd0);
        check_val("rst_StallCount", StallCount, 16'd0);
        check_val("rst_stalls", {StallF, StallD, StallE, StallM}, 16'd0);
        check_val("rst_flushes", {FlushD, FlushE, FlushW}, 16'd0);
        check_val("rst_fwd", {ForwardAE, ForwardBE}, 16'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_inputs();
        rst_n = 0;
        m_age = 0; m_err = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Forwarding priority and r0 exclusion.
        RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
        eval_cycle(1); check_val("fwd_M", ForwardAE, 2'b10); check_val("fwdB_M", ForwardBE, 2'b10); advance();
        RegWriteM = 0;
        eval_cycle(1); check_val("fwd_W", ForwardAE, 2'b01); advance();
        Rs1E = 0;
        eval_cycle(1); check_val("fwd_r0", ForwardAE, 2'b00); advance();

        // Load-use interlock for one cycle.
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        eval_cycle(1);
        check_val("lu_StallF", StallF, 1); check_val("lu_StallD", StallD, 1); check_val("lu_FlushE", FlushE, 1);
        advance();
        zero_inputs();
        eval_cycle(1); check_val("lu_release", StallF, 0); check_val("lu_count", StallCount, 16'd1);
        advance();

        // Load-use together with a taken branch.
        ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; PCSrcE = 1;
        eval_cycle(1);
        check_val("br_lu_StallF", StallF, 1); check_val("br_lu_FlushD", FlushD, 1); check_val("br_lu_FlushE", FlushE, 1);
        advance();

        // Three wait states then ack; afterwards a zero-wait access.
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            eval_cycle(1);
            check_val("mw_stall", {StallF, StallD, StallE, StallM, FlushW}, 16'h1F);
            advance();
        end
        MemAckM = 1;
        eval_cycle(1); check_val("mw_ack", {StallF, StallD, StallE, StallM, FlushW}, 16'h0); advance();
        eval_cycle(1); check_val("mw_zero_wait", StallM, 0); advance();
        zero_inputs();

        // Reset in the middle of a wait: comes back idle.
        MemReqM = 1;
        cyc(1); cyc(1);
        do_reset();
        eval_cycle(1); check_val("rst_midwait_idle", StallM, 0); advance();

        // Timeout into ERR; ack no longer helps; reset clears.
        MemReqM = 1;
        for (int i = 0; i < 16; i++) begin
            eval_cycle(1); check_val("to_stall", StallM, 1); advance();
        end
        MemReqM = 0; MemAckM = 1;
        eval_cycle(1); check_val("to_BusErr", BusErr, 1); check_val("to_held", StallF, 1); advance();
        cyc(1);
        do_reset();
        eval_cycle(1); check_val("to_cleared", {BusErr, StallF}, 16'd0); advance();

        // Branch during a memory freeze, then after ack; forwarding stays live.
        MemReqM = 1; PCSrcE = 1; RdM = 3; Rs1E = 3; RegWriteM = 1;
        for (int i = 0; i < 2; i++) begin
            eval_cycle(1);
            check_val("sim_flush_held", {FlushD, FlushE}, 16'd0);
            check_val("sim_fwd", ForwardAE, 2'b10);
            advance();
        end
        MemAckM = 1;
        eval_cycle(1); check_val("sim_flush_after", {FlushD, FlushE}, 16'h3); advance();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((i % 400) == 399 || (m_err && ($urandom % 4 == 0))) begin
                do_reset();
            end else begin
                Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
                Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
                RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
                RdW  = 5'($urandom_range(0, 3));
                RegWriteM = 1'($urandom % 2); RegWriteW = 1'($urandom % 2);
                ResultSrcE = 2'($urandom % 4);
                PCSrcE = ($urandom % 4) == 0;
                MemReqM = (m_age > 0) ? 1'b1 : (($urandom % 4) == 0);
                MemAckM = ($urandom % 3) == 0;
                cyc(1);
            end
        end

        // Saturation of the stall counter.
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        for (int i = 0; i < 65540; i++) cyc((i % 8192) == 0);
        eval_cycle(1); check_val("sat_hold", StallCount, 16'hFFFF); advance();
        eval_cycle(1); check_val("sat_nowrap", StallCount, 16'hFFFF); advance();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
